// File: rtl/spi_master_param.sv
// Parametrised SPI master: four CPOL/CPHA modes, MSB/LSB-first, variable frame
// length, several chip selects, programmable SCK half-period and start/done handshake.
module spi_master_param #(
    parameter int DATA_W  = 8,
    parameter int CS_NUM  = 2,
    parameter int CLK_DIV = 1,
    parameter int LEN_W   = 4,
    localparam int CS_W   = (CS_NUM > 1) ? $clog2(CS_NUM) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              cpol,
    input  logic              cpha,
    input  logic              lsb_first,
    input  logic [CS_W-1:0]   cs_sel,
    input  logic [LEN_W-1:0]  len,
    input  logic [DATA_W-1:0] tx_data,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] rx_data,
    input  logic              miso,
    output logic              sck,
    output logic              mosi,
    output logic [CS_NUM-1:0] cs_n
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [LEN_W-1:0]  LEN_MAX  = LEN_W'(DATA_W);
    localparam logic [LEN_W-1:0]  LEN_ONE  = LEN_W'(1'b1);
    localparam logic [LEN_W:0]    EDGE_ONE = (LEN_W + 1)'(1'b1);
    localparam logic [CS_NUM-1:0] CS_ONE   = CS_NUM'(1'b1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LEAD  = 2'd1,
        S_XFER  = 2'd2,
        S_TRAIL = 2'd3
    } state_t;

    state_t              state_r, state_nxt_s;
    logic [DIV_W-1:0]    div_cnt_r, div_cnt_nxt_s;
    logic [LEN_W:0]      edge_cnt_r, edge_cnt_nxt_s;
    logic [LEN_W-1:0]    len_r, len_nxt_s;
    logic                cpol_r, cpol_nxt_s;
    logic                cpha_r, cpha_nxt_s;
    logic                lsb_r, lsb_nxt_s;
    logic [DATA_W-1:0]   tx_r, tx_nxt_s;
    logic [DATA_W-1:0]   rx_sh_r, rx_sh_nxt_s;
    logic [DATA_W-1:0]   rx_data_r, rx_data_nxt_s;
    logic                sck_r, sck_nxt_s;
    logic                mosi_r, mosi_nxt_s;
    logic [CS_NUM-1:0]   cs_n_r, cs_n_nxt_s;
    logic                busy_r, busy_nxt_s;
    logic                done_r, done_nxt_s;

    logic                tick_s, accept_s, last_edge_s, edge_s, leading_s;
    logic [LEN_W:0]      edge_num_s;
    logic [LEN_W-1:0]    bit_s, len_eff_s;

    // Position within the word of the idx-th bit on the wire.
    function automatic logic [LEN_W-1:0] bit_pos(input logic [LEN_W-1:0] idx,
                                                 input logic [LEN_W-1:0] n,
                                                 input logic lsb);
        if (lsb) begin
            return idx;
        end else begin
            return n - idx - LEN_ONE;
        end
    endfunction

    function automatic logic pick_bit(input logic [DATA_W-1:0] word,
                                      input logic [LEN_W-1:0] pos);
        logic [DATA_W-1:0] sh;
        sh = word >> pos;
        return sh[0];
    endfunction

    assign tick_s      = (div_cnt_r == DIV_LAST);
    assign accept_s    = start && (32'(cs_sel) < 32'(CS_NUM));
    assign last_edge_s = (edge_cnt_r == {len_r, 1'b0});
    assign edge_s      = tick_s && ((state_r == S_LEAD) || ((state_r == S_XFER) && !last_edge_s));
    assign edge_num_s  = edge_cnt_r + EDGE_ONE;
    assign leading_s   = edge_num_s[0];
    assign bit_s       = edge_cnt_r[LEN_W:1];
    assign len_eff_s   = ((len == {LEN_W{1'b0}}) || (len > LEN_MAX)) ? LEN_MAX : len;

    // State and all registered outputs/datapath.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r    <= S_IDLE;
            div_cnt_r  <= {DIV_W{1'b0}};
            edge_cnt_r <= {(LEN_W + 1){1'b0}};
            len_r      <= {LEN_W{1'b0}};
            cpol_r     <= 1'b0;
            cpha_r     <= 1'b0;
            lsb_r      <= 1'b0;
            tx_r       <= {DATA_W{1'b0}};
            rx_sh_r    <= {DATA_W{1'b0}};
            rx_data_r  <= {DATA_W{1'b0}};
            sck_r      <= 1'b0;
            mosi_r     <= 1'b0;
            cs_n_r     <= {CS_NUM{1'b1}};
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            div_cnt_r  <= div_cnt_nxt_s;
            edge_cnt_r <= edge_cnt_nxt_s;
            len_r      <= len_nxt_s;
            cpol_r     <= cpol_nxt_s;
            cpha_r     <= cpha_nxt_s;
            lsb_r      <= lsb_nxt_s;
            tx_r       <= tx_nxt_s;
            rx_sh_r    <= rx_sh_nxt_s;
            rx_data_r  <= rx_data_nxt_s;
            sck_r      <= sck_nxt_s;
            mosi_r     <= mosi_nxt_s;
            cs_n_r     <= cs_n_nxt_s;
            busy_r     <= busy_nxt_s;
            done_r     <= done_nxt_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            S_IDLE:  if (accept_s) state_nxt_s = S_LEAD; else state_nxt_s = S_IDLE;
            S_LEAD:  if (tick_s) state_nxt_s = S_XFER; else state_nxt_s = S_LEAD;
            S_XFER:  if (tick_s && last_edge_s) state_nxt_s = S_TRAIL; else state_nxt_s = S_XFER;
            S_TRAIL: if (tick_s) state_nxt_s = S_IDLE; else state_nxt_s = S_TRAIL;
            default: state_nxt_s = S_IDLE;
        endcase
    end

    // Output and datapath next values; every SCK edge is a divider tick.
    always_comb begin
        div_cnt_nxt_s  = (state_r == S_IDLE || tick_s) ? {DIV_W{1'b0}} : div_cnt_r + DIV_W'(1'b1);
        edge_cnt_nxt_s = edge_cnt_r;
        len_nxt_s      = len_r;
        cpol_nxt_s     = cpol_r;
        cpha_nxt_s     = cpha_r;
        lsb_nxt_s      = lsb_r;
        tx_nxt_s       = tx_r;
        rx_sh_nxt_s    = rx_sh_r;
        rx_data_nxt_s  = rx_data_r;
        sck_nxt_s      = sck_r;
        mosi_nxt_s     = mosi_r;
        cs_n_nxt_s     = cs_n_r;
        busy_nxt_s     = busy_r;
        done_nxt_s     = 1'b0;
        case (state_r)
            S_IDLE: begin
                sck_nxt_s  = cpol;
                busy_nxt_s = 1'b0;
                cs_n_nxt_s = {CS_NUM{1'b1}};
                if (accept_s) begin
                    len_nxt_s      = len_eff_s;
                    cpol_nxt_s     = cpol;
                    cpha_nxt_s     = cpha;
                    lsb_nxt_s      = lsb_first;
                    tx_nxt_s       = tx_data;
                    rx_sh_nxt_s    = {DATA_W{1'b0}};
                    edge_cnt_nxt_s = {(LEN_W + 1){1'b0}};
                    busy_nxt_s     = 1'b1;
                    cs_n_nxt_s     = ~(CS_ONE << cs_sel);
                    if (!cpha) begin
                        mosi_nxt_s = pick_bit(tx_data, bit_pos({LEN_W{1'b0}}, len_eff_s, lsb_first));
                    end else begin
                        mosi_nxt_s = mosi_r;
                    end
                end else begin
                    rx_sh_nxt_s = rx_sh_r;
                end
            end
            S_LEAD, S_XFER: begin
                if (edge_s) begin
                    sck_nxt_s      = ~sck_r;
                    edge_cnt_nxt_s = edge_num_s;
                    if (leading_s != cpha_r) begin
                        rx_sh_nxt_s = rx_sh_r | (DATA_W'(miso) << bit_pos(bit_s, len_r, lsb_r));
                    end else begin
                        rx_sh_nxt_s = rx_sh_r;
                    end
                    if (cpha_r && leading_s) begin
                        mosi_nxt_s = pick_bit(tx_r, bit_pos(bit_s, len_r, lsb_r));
                    end else if (!cpha_r && !leading_s && (edge_num_s != {len_r, 1'b0})) begin
                        mosi_nxt_s = pick_bit(tx_r, bit_pos(bit_s + LEN_ONE, len_r, lsb_r));
                    end else begin
                        mosi_nxt_s = mosi_r;
                    end
                end else begin
                    sck_nxt_s = sck_r;
                end
            end
            S_TRAIL: begin
                if (tick_s) begin
                    busy_nxt_s    = 1'b0;
                    done_nxt_s    = 1'b1;
                    cs_n_nxt_s    = {CS_NUM{1'b1}};
                    rx_data_nxt_s = rx_sh_r;
                    sck_nxt_s     = cpol_r;
                end else begin
                    busy_nxt_s = 1'b1;
                end
            end
            default: begin
                busy_nxt_s = 1'b0;
                cs_n_nxt_s = {CS_NUM{1'b1}};
            end
        endcase
    end

    assign busy    = busy_r;
    assign done    = done_r;
    assign rx_data = rx_data_r;
    assign sck     = sck_r;
    assign mosi    = mosi_r;
    assign cs_n    = cs_n_r;

endmodule

// File: tb/tb_spi_master_param.sv
// Randomised scoreboard bench for spi_master_param with a behavioural SPI slave
// (shift-out from a bit list or loopback) and a frame-level reference model.
module tb_spi_master_param;

    localparam int DW  = 8;
    localparam int CSN = 3;
    localparam int DIV = 2;
    localparam int LW  = 4;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           start = 1'b0, cpol = 1'b0, cpha = 1'b0, lsb_first = 1'b0;
    logic [1:0]     cs_sel = 2'd0;
    logic [LW-1:0]  len = '0;
    logic [DW-1:0]  tx_data = '0;
    logic           busy, done, miso, sck, mosi;
    logic [DW-1:0]  rx_data;
    logic [CSN-1:0] cs_n;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [DW-1:0] rx;
        logic [DW-1:0] mseq;
        int            len;
        int            cs;
        logic          cpol;
    } exp_t;
    exp_t q[$];

    // pending frame for the slave, and the frame it is currently serving
    logic p_cpha = 1'b0, p_cpol = 1'b0, p_loop = 1'b1;
    int   p_len = 8;
    logic [DW-1:0] p_sbits = '0;
    logic f_cpha = 1'b0, f_cpol = 1'b0, f_loop = 1'b1;
    int   f_len = 8;
    logic [DW-1:0] f_sbits = '0;
    logic s_miso = 1'b0;
    logic [DW-1:0] cap = '0;

    assign miso = f_loop ? mosi : s_miso;

    spi_master_param #(.DATA_W(DW), .CS_NUM(CSN), .CLK_DIV(DIV), .LEN_W(LW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .cpol(cpol), .cpha(cpha),
        .lsb_first(lsb_first), .cs_sel(cs_sel), .len(len), .tx_data(tx_data),
        .busy(busy), .done(done), .rx_data(rx_data), .miso(miso), .sck(sck),
        .mosi(mosi), .cs_n(cs_n)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Slave: shifts out f_sbits in wire order and records mosi at its sample edges.
    initial begin : slave
        logic prev_act, prev_sck, act;
        int nlead, ntrail, ncap;
        prev_act = 1'b0; prev_sck = 1'b0; nlead = 0; ntrail = 0; ncap = 0;
        forever begin
            @(negedge clk);
            act = (cs_n != {CSN{1'b1}});
            if (!rst_n) begin
                prev_act = 1'b0;
            end else if (act && !prev_act) begin
                f_cpha = p_cpha; f_cpol = p_cpol; f_loop = p_loop;
                f_len = p_len; f_sbits = p_sbits;
                nlead = 0; ntrail = 0; ncap = 0; cap = '0;
                if (!f_cpha) s_miso = f_sbits[0];
            end else if (act && sck != prev_sck) begin
                if (sck != f_cpol) begin
                    if (!f_cpha) begin
                        if (ncap < DW) cap[ncap] = mosi;
                        ncap++;
                    end else begin
                        if (nlead < f_len) s_miso = f_sbits[nlead];
                        nlead++;
                    end
                end else begin
                    ntrail++;
                    if (!f_cpha) begin
                        if (ntrail < f_len) s_miso = f_sbits[ntrail];
                    end else begin
                        if (ncap < DW) cap[ncap] = mosi;
                        ncap++;
                    end
                end
            end
            prev_act = act;
            prev_sck = sck;
        end
    end

    // Monitor: measures each frame and scores it against the queue on done.
    initial begin : monitor
        logic pbusy, psck, cs_bad;
        logic [CSN-1:0] exp_cs;
        int nbusy, nrise, nfall;
        exp_t e;
        pbusy = 1'b0; psck = 1'b0; cs_bad = 1'b0; nbusy = 0; nrise = 0; nfall = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                pbusy = 1'b0;
                psck  = sck;
                continue;
            end
            if (busy && !pbusy) begin
                nbusy = 0; nrise = 0; nfall = 0; cs_bad = 1'b0;
            end
            if (busy) begin
                nbusy++;
                if (pbusy && sck !== psck) begin
                    if (sck) nrise++; else nfall++;
                end
                if (q.size() > 0) begin
                    exp_cs = {CSN{1'b1}};
                    exp_cs[q[0].cs] = 1'b0;
                    if (cs_n !== exp_cs) cs_bad = 1'b1;
                end
            end
            if (done) begin
                if (q.size() == 0) begin
                    check("unexpected_done", 32'(done), 32'(0));
                end else begin
                    e = q.pop_front();
                    check("rx_data", 32'(rx_data), 32'(e.rx));
                    check("mosi_seq", 32'(cap), 32'(e.mseq));
                    check("busy_cycles", 32'(nbusy), 32'(DIV * (2 * e.len + 2)));
                    check("sck_rise", 32'(nrise), 32'(e.len));
                    check("sck_fall", 32'(nfall), 32'(e.len));
                    check("cs_during", 32'(cs_bad), 32'(0));
                    check("cs_done_high", 32'(cs_n), 32'({CSN{1'b1}}));
                    check("sck_idle", 32'(sck), 32'(e.cpol));
                end
            end
            pbusy = busy;
            psck  = sck;
        end
    end

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check("idle_timeout", 32'(busy), 32'(0));
    endtask

    task automatic wait_done();
        int n = 0;
        while (!done && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check("done_timeout", 32'(done), 32'(1));
    endtask

    // Reference model: wire order and expected result from the frame rules.
    task automatic issue(input logic cp, input logic ch, input logic lsb, input int cs,
                         input int ln, input logic [DW-1:0] tx, input logic [DW-1:0] sw,
                         input logic loop);
        exp_t e;
        int leff, pos;
        logic [DW-1:0] sb, mask;
        leff = (ln == 0 || ln > DW) ? DW : ln;
        sb = '0; mask = '0; e.mseq = '0;
        for (int i = 0; i < leff; i++) begin
            pos = lsb ? i : leff - 1 - i;
            sb[i] = sw[pos];
            e.mseq[i] = tx[pos];
            mask[i] = 1'b1;
        end
        e.rx = (loop ? tx : sw) & mask;
        e.len = leff; e.cs = cs; e.cpol = cp;
        p_cpha = ch; p_cpol = cp; p_loop = loop; p_len = leff; p_sbits = sb;
        q.push_back(e);
        cpol = cp; cpha = ch; lsb_first = lsb; cs_sel = 2'(cs);
        len = LW'(ln); tx_data = tx; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin : driver
        logic [1:0] m;
        logic [CSN-1:0] one_hot;
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_done", 32'(done), 32'(0));
        check("rst_rx", 32'(rx_data), 32'(0));
        check("rst_sck", 32'(sck), 32'(0));
        check("rst_mosi", 32'(mosi), 32'(0));
        check("rst_cs", 32'(cs_n), 32'({CSN{1'b1}}));
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 4; i++) begin
            m = 2'(i);
            wait_idle();
            repeat (2) @(negedge clk);
            issue(m[1], m[0], 1'b0, 0, 8, 8'hA5, 8'h00, 1'b1);
        end
        wait_idle();
        issue(1'b0, 1'b0, 1'b1, 1, 8, 8'h81, 8'h3C, 1'b0);
        wait_idle();
        issue(1'b0, 1'b0, 1'b0, 2, 5, 8'h16, 8'h00, 1'b1);
        wait_idle();
        issue(1'b1, 1'b0, 1'b0, 0, 0, 8'hC3, 8'h00, 1'b1);

        // out-of-range chip select is ignored
        wait_idle();
        repeat (2) @(negedge clk);
        cs_sel = 2'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        check("bad_cs_busy", 32'(busy), 32'(0));
        check("bad_cs_csn", 32'(cs_n), 32'({CSN{1'b1}}));

        // start mid-transfer ignored, start in done cycle accepted back-to-back
        issue(1'b1, 1'b1, 1'b0, 2, 8, 8'h5A, 8'hE7, 1'b0);
        repeat (6) @(negedge clk);
        cs_sel = 2'd1; tx_data = 8'hFF; cpha = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done();
        issue(1'b0, 1'b1, 1'b1, 1, 7, 8'h4B, 8'h2D, 1'b0);
        one_hot = {CSN{1'b1}};
        one_hot[1] = 1'b0;
        check("b2b_busy", 32'(busy), 32'(1));
        check("b2b_cs_low", 32'(cs_n), 32'(one_hot));

        // reset in the middle of a frame
        wait_idle();
        issue(1'b0, 1'b0, 1'b0, 0, 8, 8'h96, 8'h00, 1'b1);
        repeat (18) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("abort_cs", 32'(cs_n), 32'({CSN{1'b1}}));
        check("abort_sck", 32'(sck), 32'(0));
        check("abort_busy", 32'(busy), 32'(0));
        check("abort_done", 32'(done), 32'(0));
        void'(q.pop_back());
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        issue(1'b0, 1'b0, 1'b0, 0, 8, 8'h96, 8'h00, 1'b1);

        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 1) == 0) begin
                wait_done();
            end else begin
                wait_idle();
                repeat ($urandom_range(1, 3)) @(negedge clk);
            end
            issue(1'($urandom), 1'($urandom), 1'($urandom), $urandom_range(0, CSN - 1),
                  $urandom_range(0, 15), DW'($urandom), DW'($urandom), 1'($urandom));
        end
        wait_idle();
        repeat (5) @(negedge clk);
        check("queue_empty", 32'(q.size()), 32'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
